l1_cache_control: RTL and testbench

Control block for the direct-mapped L1 cache. It is the stage that drives the 8-entry, 128-bit line data array: it owns the tag, valid and dirty state, checks CPU requests for hits, and sequences dirty-line writeback and line fill against physical memory. It generates the data array's write strobe, index and input-select. The data merge and the line storage themselves stay in the cache datapath.

---
 rtl/l1_cache_control_if.sv | 40 ++++
 rtl/l1_cache_control.sv | 125 ++++++++++++
 tb/tb_l1_cache_control.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/l1_cache_control_if.sv
// l1_cache_control_if
//   Bundles the CPU request port, the physical-memory line port and the
//   data-array control signals of the L1 cache controller.
//
//   Handshake rules:
//   - CPU side: mem_read/mem_write (the request) stay asserted, with
//     mem_address stable, until the cycle in which mem_resp is high.
//     mem_resp is a single-cycle completion pulse.
//   - pmem side: pmem_read/pmem_write stay asserted, with pmem_address
//     stable, up to and including the cycle in which pmem_resp is sampled
//     high. They are never asserted together.
//
//   Modports:
//   - slave  : the cache controller view (takes CPU requests, drives pmem).
//   - master : the environment view (CPU plus physical memory).
interface l1_cache_control_if;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_address;
  logic        mem_resp;
  logic        pmem_read;
  logic        pmem_write;
  logic [15:0] pmem_address;
  logic        pmem_resp;
  logic [2:0]  arr_index;
  logic        arr_write;
  logic        arr_sel;

  modport slave (
    input  mem_read, mem_write, mem_address, pmem_resp,
    output mem_resp, pmem_read, pmem_write, pmem_address,
    output arr_index, arr_write, arr_sel
  );

  modport master (
    output mem_read, mem_write, mem_address, pmem_resp,
    input  mem_resp, pmem_read, pmem_write, pmem_address,
    input  arr_index, arr_write, arr_sel
  );
endinterface

// File: rtl/l1_cache_control.sv
// l1_cache_control
//   Control block of the direct-mapped L1 cache. Holds tag/valid/dirty per
//   set, detects hits, and sequences dirty-line writeback and line fill
//   against physical memory. Drives the data array's index, write enable
//   and datain select; the line storage and data merge live elsewhere.
//
//   Ports:
//   - clk       : system clock, rising edge
//   - reset     : asynchronous, active-high
//   - bus       : l1_cache_control_if.slave (CPU, pmem and array signals)
//   - state_dbg : current FSM state (0 = CHECK, 1 = WRITEBACK, 2 = FILL)
//
//   Address split: tag = mem_address[15:7], index = [6:4], offset = [3:0].
//   All bus outputs are combinational from state and inputs.
module l1_cache_control #(
  parameter int TAG_W = 9,
  parameter int SETS  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  l1_cache_control_if.slave    bus,
  output logic [1:0]           state_dbg
);

  localparam logic [1:0] S_CHECK     = 2'd0;
  localparam logic [1:0] S_WRITEBACK = 2'd1;
  localparam logic [1:0] S_FILL      = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [TAG_W-1:0] tag_q [SETS];
  logic [TAG_W-1:0] tag_d [SETS];
  logic [SETS-1:0]  valid_q, valid_d;
  logic [SETS-1:0]  dirty_q, dirty_d;

  logic [2:0]       idx;
  logic [TAG_W-1:0] req_tag;
  logic             req;
  logic             hit;

  assign idx       = bus.mem_address[6:4];
  assign req_tag   = bus.mem_address[15:16-TAG_W];
  // A simultaneous read+write is handled as a write, so mem_write alone
  // decides whether the hit cycle merges into the array.
  assign req       = bus.mem_read | bus.mem_write;
  assign hit       = valid_q[idx] & (tag_q[idx] == req_tag);
  assign state_dbg = state_q;
  assign bus.arr_index = idx;

  always_comb begin
    state_d          = state_q;
    tag_d            = tag_q;
    valid_d          = valid_q;
    dirty_d          = dirty_q;
    bus.mem_resp     = 1'b0;
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_address = 16'h0000;
    bus.arr_write    = 1'b0;
    bus.arr_sel      = 1'b0;

    case (state_q)
      S_CHECK: begin
        // pmem_resp is deliberately ignored here.
        if (req) begin
          if (hit) begin
            bus.mem_resp = 1'b1;
            if (bus.mem_write) begin
              bus.arr_write = 1'b1;
              dirty_d[idx]  = 1'b1;
            end
          end else if (valid_q[idx] && dirty_q[idx]) begin
            state_d = S_WRITEBACK;
          end else begin
            state_d = S_FILL;
          end
        end
      end

      S_WRITEBACK: begin
        // Victim line address comes from the stored tag, not the request.
        bus.pmem_write   = 1'b1;
        bus.pmem_address = {tag_q[idx], idx, 4'b0000};
        if (bus.pmem_resp) begin
          dirty_d[idx] = 1'b0;
          state_d      = S_FILL;
        end
      end

      S_FILL: begin
        bus.pmem_read    = 1'b1;
        bus.pmem_address = {bus.mem_address[15:4], 4'b0000};
        if (bus.pmem_resp) begin
          bus.arr_write = 1'b1;
          bus.arr_sel   = 1'b1;
          tag_d[idx]    = req_tag;
          valid_d[idx]  = 1'b1;
          dirty_d[idx]  = 1'b0;
          // The request completes on the following CHECK cycle as a hit.
          state_d       = S_CHECK;
        end
      end

      default: state_d = S_CHECK;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_CHECK;
      valid_q <= '0;
      dirty_q <= '0;
      for (int i = 0; i < SETS; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      for (int i = 0; i < SETS; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

endmodule

// File: tb/tb_l1_cache_control.sv
// tb_l1_cache_control
//   Self-checking bench for l1_cache_control: directed scenarios followed by
//   randomized CPU traffic, checked against a per-set tag/valid/dirty model.
module tb_l1_cache_control;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  l1_cache_control_if bus();

  l1_cache_control #(.TAG_W(9), .SETS(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // ---------------- reference model ----------------
  logic [8:0]  m_tag   [8];
  bit          m_valid [8];
  bit          m_dirty [8];
  logic [15:0] exp_q [$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_tag[i]   = '0;
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    exp_q.delete();
  endtask

  // ---------------- checking ----------------
  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic expect_outs(input string name, input bit resp, input bit pr, input bit pw,
                             input bit aw, input bit as, input logic [15:0] pa,
                             input logic [2:0] idx);
    check_eq({name, ".mem_resp"},     32'(bus.mem_resp),     32'(resp));
    check_eq({name, ".pmem_read"},    32'(bus.pmem_read),    32'(pr));
    check_eq({name, ".pmem_write"},   32'(bus.pmem_write),   32'(pw));
    check_eq({name, ".arr_write"},    32'(bus.arr_write),    32'(aw));
    check_eq({name, ".arr_sel"},      32'(bus.arr_sel),      32'(as));
    check_eq({name, ".pmem_address"}, 32'(bus.pmem_address), 32'(pa));
    check_eq({name, ".arr_index"},    32'(bus.arr_index),    32'(idx));
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_cycle(input bit pr);
    @(negedge clk);
    bus.pmem_resp = pr;
    #1;
    expect_outs("idle", 0, 0, 0, 0, 0, 16'h0, bus.mem_address[6:4]);
    #1 bus.pmem_resp = 1'b0;
  endtask

  // One complete CPU request. wb_lat/fill_lat = cycles spent in that phase
  // before (and including) the pmem_resp cycle; 0 picks a random latency.
  task automatic run_req(input logic [15:0] addr, input bit rd, input bit wr,
                         input int wb_lat, input int fill_lat);
    logic [2:0]  idx;
    logic [8:0]  tg;
    logic [15:0] victim;
    logic [15:0] exp_addr;
    bit          hit, wb;
    idx    = addr[6:4];
    tg     = addr[15:7];
    hit    = m_valid[idx] && (m_tag[idx] == tg);
    wb     = !hit && m_valid[idx] && m_dirty[idx];
    victim = {m_tag[idx], idx, 4'h0};
    if (wb_lat == 0)   wb_lat   = $urandom_range(1, 4);
    if (fill_lat == 0) fill_lat = $urandom_range(1, 4);
    exp_q.push_back(addr);

    @(negedge clk);
    bus.mem_read    = rd;
    bus.mem_write   = wr;
    bus.mem_address = addr;
    #1;
    if (!hit) begin
      expect_outs("miss_check", 0, 0, 0, 0, 0, 16'h0, idx);
      if (wb) begin
        for (int c = 1; c <= wb_lat; c++) begin
          @(negedge clk);
          bus.pmem_resp = (c == wb_lat);
          #1;
          expect_outs("writeback", 0, 0, 1, 0, 0, victim, idx);
        end
        m_dirty[idx] = 1'b0;
      end
      for (int c = 1; c <= fill_lat; c++) begin
        @(negedge clk);
        bus.pmem_resp = (c == fill_lat);
        #1;
        expect_outs("fill", 0, 1, 0, c == fill_lat, c == fill_lat, {addr[15:4], 4'h0}, idx);
      end
      m_tag[idx]   = tg;
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      @(negedge clk);
      bus.pmem_resp = 1'b0;
      #1;
    end
    expect_outs("hit", 1, 0, 0, wr, 0, 16'h0, idx);
    if (bus.mem_resp === 1'b1) begin
      if (exp_q.size() > 0) begin
        exp_addr = exp_q.pop_front();
        check_eq("sb_addr", 32'(bus.mem_address), 32'(exp_addr));
      end else begin
        check_eq("sb_unexpected_resp", 32'(exp_q.size()), 32'd1);
      end
    end
    if (wr) m_dirty[idx] = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
  endtask

  // Read miss interrupted by reset while the fill is outstanding.
  task automatic reset_mid_fill(input logic [15:0] addr);
    @(negedge clk);
    bus.mem_read    = 1'b1;
    bus.mem_write   = 1'b0;
    bus.mem_address = addr;
    @(negedge clk);
    #1;
    check_eq("rst_fill.pmem_read_before", 32'(bus.pmem_read), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("rst_fill.pmem_read_after", 32'(bus.pmem_read), 32'd0);
    check_eq("rst_fill.mem_resp",        32'(bus.mem_resp),  32'd0);
    check_eq("rst_fill.arr_write",       32'(bus.arr_write), 32'd0);
    @(negedge clk);
    bus.mem_read = 1'b0;
    reset        = 1'b0;
    model_reset();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] a;
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.mem_address = 16'h0000;
    bus.pmem_resp   = 1'b0;
    reset           = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    expect_outs("reset", 0, 0, 0, 0, 0, 16'h0, 3'd0);
    @(negedge clk);
    reset = 1'b0;

    idle_cycle(1'b0);
    idle_cycle(1'b1);                       // stray pmem_resp in CHECK
    run_req(16'h1230, 1, 0, 0, 3);          // cold miss, fill latency 3
    run_req(16'h123E, 1, 0, 0, 0);          // hit
    run_req(16'h1232, 0, 1, 0, 0);          // write hit -> dirty
    run_req(16'h5230, 1, 0, 2, 3);          // dirty eviction of 0x1230
    run_req(16'h1230, 1, 0, 0, 1);          // clean eviction back
    run_req(16'h1234, 1, 1, 0, 0);          // read+write hit = write
    run_req(16'h5230, 1, 0, 1, 1);          // must write back again
    idle_cycle(1'b0);

    reset_mid_fill(16'h7770);
    run_req(16'h7770, 1, 0, 0, 0);          // misses again after reset

    for (int n = 0; n < 200; n++) begin
      a = {7'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           3'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
      case ($urandom_range(0, 3))
        0: run_req(a, 1, 0, 0, 0);
        1: run_req(a, 0, 1, 0, 0);
        2: run_req(a, 1, 1, 0, 0);
        default: idle_cycle(1'($urandom_range(0, 1)));
      endcase
    end

    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
